// File: rtl/qdr_client_arbiter.sv
// Two-client round-robin arbiter in front of one QDR controller user port, with a tag FIFO that routes read data.
// Optional statistics outputs are enabled by defining QDR_ARB_STATS_EN.
module qdr_client_arbiter #(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 36,
  parameter int BE_WIDTH   = 4,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                   clk0,
  input  logic                   reset,
  input  logic                   phy_rdy,
  input  logic                   a_req,
  input  logic                   a_rnw,
  input  logic [ADDR_WIDTH-1:0]  a_addr,
  input  logic [DATA_WIDTH-1:0]  a_wr_data,
  input  logic [BE_WIDTH-1:0]    a_wr_be,
  output logic                   a_ack,
  output logic [DATA_WIDTH-1:0]  a_rd_data,
  output logic                   a_rd_dvld,
  input  logic                   b_req,
  input  logic                   b_rnw,
  input  logic [ADDR_WIDTH-1:0]  b_addr,
  input  logic [DATA_WIDTH-1:0]  b_wr_data,
  input  logic [BE_WIDTH-1:0]    b_wr_be,
  output logic                   b_ack,
  output logic [DATA_WIDTH-1:0]  b_rd_data,
  output logic                   b_rd_dvld,
  output logic [ADDR_WIDTH-1:0]  usr_addr,
  output logic                   usr_wr_strb,
  output logic [DATA_WIDTH-1:0]  usr_wr_data,
  output logic [BE_WIDTH-1:0]    usr_wr_be,
  output logic                   usr_rd_strb,
  input  logic [DATA_WIDTH-1:0]  usr_rd_data,
  input  logic                   usr_rd_dvld,
  output logic                   tag_err
`ifdef QDR_ARB_STATS_EN
  ,
  output logic [31:0]            a_grant_cnt,
  output logic [31:0]            b_grant_cnt,
  output logic [$clog2(TAG_DEPTH):0] max_outstanding
`endif
);

  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic                  rr_q, rr_d;
  logic [TAG_DEPTH-1:0]  tag_q, tag_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  logic [ADDR_WIDTH-1:0] usr_addr_q, usr_addr_d;
  logic                  usr_wr_strb_q, usr_wr_strb_d;
  logic                  usr_rd_strb_q, usr_rd_strb_d;
  logic [DATA_WIDTH-1:0] usr_wr_data_q, usr_wr_data_d;
  logic [BE_WIDTH-1:0]   usr_wr_be_q, usr_wr_be_d;

  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  a_rd_dvld_q, a_rd_dvld_d;
  logic                  b_rd_dvld_q, b_rd_dvld_d;
  logic                  tag_err_q, tag_err_d;

  logic fifo_full, fifo_empty;
  logic a_elig, b_elig;
  logic grant_a, grant_b, grant;
  logic win_rnw;
  logic push, pop, pop_id;

  assign fifo_full  = (count_q == CW'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Gating with reset keeps the combinational acks low while reset is held.
  assign a_elig = ~reset & phy_rdy & a_req & (~a_rnw | ~fifo_full);
  assign b_elig = ~reset & phy_rdy & b_req & (~b_rnw | ~fifo_full);

  assign grant_a = a_elig & (~b_elig | ~rr_q);
  assign grant_b = b_elig & ~grant_a;
  assign grant   = grant_a | grant_b;
  assign win_rnw = grant_a ? a_rnw : b_rnw;

  assign push   = grant & win_rnw;
  assign pop    = usr_rd_dvld & ~fifo_empty;
  assign pop_id = tag_q[rd_ptr_q];

  always_comb begin
    rr_d          = rr_q;
    tag_d         = tag_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    usr_addr_d    = usr_addr_q;
    usr_wr_strb_d = 1'b0;
    usr_rd_strb_d = 1'b0;
    usr_wr_data_d = usr_wr_data_q;
    usr_wr_be_d   = usr_wr_be_q;
    rd_data_d     = rd_data_q;
    a_rd_dvld_d   = 1'b0;
    b_rd_dvld_d   = 1'b0;
    tag_err_d     = tag_err_q | (usr_rd_dvld & fifo_empty);

    // Pointer always moves to the client that did not win.
    if (grant_a) rr_d = 1'b1;
    if (grant_b) rr_d = 1'b0;

    if (grant) begin
      usr_addr_d    = grant_a ? a_addr : b_addr;
      usr_wr_strb_d = ~win_rnw;
      usr_rd_strb_d = win_rnw;
      if (!win_rnw) begin
        usr_wr_data_d = grant_a ? a_wr_data : b_wr_data;
        usr_wr_be_d   = grant_a ? a_wr_be   : b_wr_be;
      end
    end

    if (push) begin
      tag_d[wr_ptr_q] = grant_b;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      a_rd_dvld_d = ~pop_id;
      b_rd_dvld_d = pop_id;
    end

    if (usr_rd_dvld) rd_data_d = usr_rd_data;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      rr_q          <= 1'b0;
      tag_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      usr_addr_q    <= '0;
      usr_wr_strb_q <= 1'b0;
      usr_rd_strb_q <= 1'b0;
      usr_wr_data_q <= '0;
      usr_wr_be_q   <= '0;
      rd_data_q     <= '0;
      a_rd_dvld_q   <= 1'b0;
      b_rd_dvld_q   <= 1'b0;
      tag_err_q     <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      tag_q         <= tag_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      usr_addr_q    <= usr_addr_d;
      usr_wr_strb_q <= usr_wr_strb_d;
      usr_rd_strb_q <= usr_rd_strb_d;
      usr_wr_data_q <= usr_wr_data_d;
      usr_wr_be_q   <= usr_wr_be_d;
      rd_data_q     <= rd_data_d;
      a_rd_dvld_q   <= a_rd_dvld_d;
      b_rd_dvld_q   <= b_rd_dvld_d;
      tag_err_q     <= tag_err_d;
    end
  end

  assign a_ack       = grant_a;
  assign b_ack       = grant_b;
  assign usr_addr    = usr_addr_q;
  assign usr_wr_strb = usr_wr_strb_q;
  assign usr_rd_strb = usr_rd_strb_q;
  assign usr_wr_data = usr_wr_data_q;
  assign usr_wr_be   = usr_wr_be_q;
  assign a_rd_data   = rd_data_q;
  assign b_rd_data   = rd_data_q;
  assign a_rd_dvld   = a_rd_dvld_q;
  assign b_rd_dvld   = b_rd_dvld_q;
  assign tag_err     = tag_err_q;

`ifdef QDR_ARB_STATS_EN
  logic [31:0] a_cnt_q, a_cnt_d;
  logic [31:0] b_cnt_q, b_cnt_d;
  logic [CW-1:0] max_q, max_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    max_d   = max_q;
    if (grant_a && (a_cnt_q != '1)) a_cnt_d = a_cnt_q + 32'd1;
    if (grant_b && (b_cnt_q != '1)) b_cnt_d = b_cnt_q + 32'd1;
    if (count_d > max_q) max_d = count_d;
  end

  always_ff @(posedge clk0 or posedge reset) begin
    if (reset) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      max_q   <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      max_q   <= max_d;
    end
  end

  assign a_grant_cnt     = a_cnt_q;
  assign b_grant_cnt     = b_cnt_q;
  assign max_outstanding = max_q;
`endif

endmodule
